// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Arbitrates two writeback requesters onto a single register-file write port.
// It also keeps a 32-entry busy scoreboard of destination registers that have
// a reservation from issue but have not yet been written back.
//
// Handshake semantics (both requesters): a transfer happens in a cycle where
// wbN_valid and wbN_ready are both 1. wbN_ready is combinational and is only
// raised for the arbitration winner, so at most one transfer happens per
// cycle. A requester that is not granted must hold valid, reg and data stable.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   rsv_valid, rsv_reg      destination reservation from issue
//   wb0_valid/reg/data/ready ALU writeback requester
//   wb1_valid/reg/data/ready load / multi-cycle writeback requester
//   chk_reg1/2, chk_busy1/2 decode source-operand busy lookups
//   EnableWrite, write_reg, write_data  registered register-file write port
//   busy_map                scoreboard, bit n = register n has a pending write
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_reg,
  input  logic              wb0_valid,
  input  logic [ADDR_W-1:0] wb0_reg,
  input  logic [DATA_W-1:0] wb0_data,
  output logic              wb0_ready,
  input  logic              wb1_valid,
  input  logic [ADDR_W-1:0] wb1_reg,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              wb1_ready,
  input  logic [ADDR_W-1:0] chk_reg1,
  input  logic [ADDR_W-1:0] chk_reg2,
  output logic              chk_busy1,
  output logic              chk_busy2,
  output logic              EnableWrite,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic [31:0]       busy_map
);

  // 0: wb0 won the most recent transfer, 1: wb1 did.
  logic              last_grant;
  logic              grant0;
  logic              grant1;
  logic              hs;
  logic [ADDR_W-1:0] win_reg;
  logic [DATA_W-1:0] win_data;
  logic [31:0]       set_mask;
  logic [31:0]       clr_mask;
  logic [31:0]       busy_next;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    // Readies are held low while reset is asserted, independent of the
    // clock, so no transfer can be accepted during reset.
    if (rst_n) begin
      if (wb0_valid && wb1_valid) begin
        // Contention: the requester that did not win last time goes next.
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = wb0_valid;
        grant1 = wb1_valid;
      end
    end
    hs       = grant0 || grant1;
    win_reg  = grant1 ? wb1_reg  : wb0_reg;
    win_data = grant1 ? wb1_data : wb0_data;
    clr_mask = hs ? (32'd1 << win_reg) : 32'd0;
    // Register 0 is never tracked as busy.
    set_mask = (rsv_valid && (rsv_reg != '0)) ? (32'd1 << rsv_reg) : 32'd0;
    // Set is applied after clear so a same-cycle reservation wins.
    busy_next = (busy_map & ~clr_mask) | set_mask;
  end

  assign wb0_ready = grant0;
  assign wb1_ready = grant1;

  assign chk_busy1 = (chk_reg1 != '0) && (|(busy_map & (32'd1 << chk_reg1)));
  assign chk_busy2 = (chk_reg2 != '0) && (|(busy_map & (32'd1 << chk_reg2)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant  <= 1'b1;
      EnableWrite <= 1'b0;
      write_reg   <= '0;
      write_data  <= '0;
      busy_map    <= '0;
    end else begin
      busy_map <= busy_next;
      if (hs) begin
        last_grant  <= grant1;
        write_reg   <= win_reg;
        write_data  <= win_data;
        // Writes to register 0 are accepted but never strobed.
        EnableWrite <= (win_reg != '0);
      end else begin
        EnableWrite <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Self-checking bench for regfile_wb_arbiter. A small reference model of the
// arbitration pointer, the scoreboard and the write port is advanced each
// cycle; the expected register-file write for each cycle is pushed to exp_q
// when the stimulus is driven and popped when the DUT output is sampled.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int ENT_W  = 1 + ADDR_W + DATA_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic              rsv_valid = 1'b0;
  logic [ADDR_W-1:0] rsv_reg = '0;
  logic              wb0_valid = 1'b0;
  logic [ADDR_W-1:0] wb0_reg = '0;
  logic [DATA_W-1:0] wb0_data = '0;
  logic              wb0_ready;
  logic              wb1_valid = 1'b0;
  logic [ADDR_W-1:0] wb1_reg = '0;
  logic [DATA_W-1:0] wb1_data = '0;
  logic              wb1_ready;
  logic [ADDR_W-1:0] chk_reg1 = '0;
  logic [ADDR_W-1:0] chk_reg2 = '0;
  logic              chk_busy1;
  logic              chk_busy2;
  logic              EnableWrite;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic [31:0]       busy_map;

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rsv_valid  (rsv_valid),
    .rsv_reg    (rsv_reg),
    .wb0_valid  (wb0_valid),
    .wb0_reg    (wb0_reg),
    .wb0_data   (wb0_data),
    .wb0_ready  (wb0_ready),
    .wb1_valid  (wb1_valid),
    .wb1_reg    (wb1_reg),
    .wb1_data   (wb1_data),
    .wb1_ready  (wb1_ready),
    .chk_reg1   (chk_reg1),
    .chk_reg2   (chk_reg2),
    .chk_busy1  (chk_busy1),
    .chk_busy2  (chk_busy2),
    .EnableWrite(EnableWrite),
    .write_reg  (write_reg),
    .write_data (write_data),
    .busy_map   (busy_map)
  );

  // scoreboard / model state
  logic [ENT_W-1:0]  exp_q[$];
  int                n_checks = 0;
  int                n_errors = 0;
  logic              m_last;
  logic [31:0]       m_busy;
  logic [ADDR_W-1:0] m_wreg;
  logic [DATA_W-1:0] m_wdata;
  logic              last_g0;
  logic              last_g1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic model_busy(input logic [ADDR_W-1:0] r);
    return (r != '0) && m_busy[r];
  endfunction

  // Enters and leaves at posedge+1.
  task automatic drive_cycle(
    input logic v0, input logic [ADDR_W-1:0] r0, input logic [DATA_W-1:0] d0,
    input logic v1, input logic [ADDR_W-1:0] r1, input logic [DATA_W-1:0] d1,
    input logic rv, input logic [ADDR_W-1:0] rr
  );
    logic g0, g1, en;
    logic [ADDR_W-1:0] wr;
    logic [DATA_W-1:0] wd;
    logic [ENT_W-1:0]  ent;
    wb0_valid = v0; wb0_reg = r0; wb0_data = d0;
    wb1_valid = v1; wb1_reg = r1; wb1_data = d1;
    rsv_valid = rv; rsv_reg = rr;
    #1;
    g0 = v0 && (!v1 || m_last);
    g1 = v1 && (!v0 || !m_last);
    last_g0 = g0;
    last_g1 = g1;
    check("wb0_ready", 64'(wb0_ready), 64'(g0));
    check("wb1_ready", 64'(wb1_ready), 64'(g1));
    check("chk_busy1", 64'(chk_busy1), 64'(model_busy(chk_reg1)));
    check("chk_busy2", 64'(chk_busy2), 64'(model_busy(chk_reg2)));
    en = 1'b0;
    if (g0 || g1) begin
      wr = g1 ? r1 : r0;
      wd = g1 ? d1 : d0;
      m_last  = g1;
      m_wreg  = wr;
      m_wdata = wd;
      en      = (wr != '0);
      m_busy[wr] = 1'b0;
    end
    if (rv && rr != '0) m_busy[rr] = 1'b1;
    exp_q.push_back({en, m_wreg, m_wdata});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 64'd0, 64'd1);
    end else begin
      ent = exp_q.pop_front();
      check("EnableWrite", 64'(EnableWrite), 64'(ent[ENT_W-1]));
      check("write_reg",   64'(write_reg),   64'(ent[ENT_W-2 -: ADDR_W]));
      check("write_data",  64'(write_data),  64'(ent[DATA_W-1:0]));
    end
    check("busy_map", 64'(busy_map), 64'(m_busy));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0, '0, '0, 0, '0, '0, 0, '0);
  endtask

  // Asserts reset off-edge, checks the asynchronous effect, releases it.
  task automatic do_reset;
    rst_n = 1'b0;
    wb0_valid = 1'b1; wb0_reg = 5'd3;
    wb1_valid = 1'b1; wb1_reg = 5'd4;
    #1;
    check("rst_EnableWrite", 64'(EnableWrite), 64'd0);
    check("rst_write_reg",   64'(write_reg),   64'd0);
    check("rst_write_data",  64'(write_data),  64'd0);
    check("rst_busy_map",    64'(busy_map),    64'd0);
    check("rst_wb0_ready",   64'(wb0_ready),   64'd0);
    check("rst_wb1_ready",   64'(wb1_ready),   64'd0);
    @(posedge clk);
    #1;
    check("rst_hold_EnableWrite", 64'(EnableWrite), 64'd0);
    wb0_valid = 1'b0; wb1_valid = 1'b0; rsv_valid = 1'b0;
    rst_n = 1'b1;
    m_last = 1'b1; m_busy = '0; m_wreg = '0; m_wdata = '0;
    exp_q.delete();
  endtask

  initial begin
    logic              v0, v1, rv;
    logic [ADDR_W-1:0] r0, r1, rr;
    logic [DATA_W-1:0] d0, d1;
    #2;
    do_reset();

    // single ALU writeback, latency one
    drive_cycle(1, 5'd7, 32'hDEADBEEF, 0, '0, '0, 0, '0);
    idle(1);

    // contention from reset: grants alternate wb0, wb1, wb0, wb1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1, 5'd3, 32'h3333_0000 + 32'(i), 1, 5'd4, 32'h4444_0000 + 32'(i), 0, '0);
      check("alt_grant_wb0", 64'(last_g0), 64'((i % 2) == 0));
    end
    idle(1);

    // reservation, lookup, then wb1 clears it
    chk_reg1 = 5'd9; chk_reg2 = 5'd0;
    drive_cycle(0, '0, '0, 0, '0, '0, 1, 5'd9);
    check("busy9_set", 64'(chk_busy1), 64'd1);
    drive_cycle(0, '0, '0, 1, 5'd9, 32'h0000_0999, 0, '0);
    check("busy9_clr", 64'(chk_busy1), 64'd0);

    // same-cycle set and clear of register 5: set wins
    chk_reg2 = 5'd5;
    drive_cycle(0, '0, '0, 0, '0, '0, 1, 5'd5);
    drive_cycle(1, 5'd5, 32'h5555_5555, 0, '0, '0, 1, 5'd5);
    check("busy5_kept", 64'(busy_map[5]), 64'd1);
    idle(1);

    // register 0: accepted, never strobed, never reserved
    do_reset();
    drive_cycle(1, 5'd0, 32'h0BAD_0BAD, 0, '0, '0, 1, 5'd0);
    check("r0_busy_map", 64'(busy_map), 64'd0);
    idle(1);

    // random traffic; a losing requester holds its request
    v0 = 0; v1 = 0; r0 = '0; r1 = '0; d0 = '0; d1 = '0;
    last_g0 = 1'b0; last_g1 = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!(v0 && !last_g0)) begin
        v0 = 1'($urandom_range(0, 1)); r0 = 5'($urandom_range(0, 31)); d0 = $urandom;
      end
      if (!(v1 && !last_g1)) begin
        v1 = 1'($urandom_range(0, 1)); r1 = 5'($urandom_range(0, 31)); d1 = $urandom;
      end
      rv = 1'($urandom_range(0, 1));
      rr = 5'($urandom_range(0, 31));
      chk_reg1 = 5'($urandom_range(0, 31));
      chk_reg2 = 5'($urandom_range(0, 31));
      drive_cycle(v0, r0, d0, v1, r1, d1, rv, rr);
    end
    idle(1);

    // reset in the cycle after a handshake discards the pending write
    drive_cycle(0, '0, '0, 0, '0, '0, 1, 5'd20);
    drive_cycle(1, 5'd12, 32'hCAFE_F00D, 0, '0, '0, 0, '0);
    do_reset();
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the write-data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning the register index width (32 registers).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port rsv_valid, input, 1 bit: the issue stage reserves a destination register this cycle.
REQ-006 The block SHALL have port rsv_reg, input, ADDR_W: the destination register being reserved.
REQ-007 The block SHALL have ports wb0_valid (in, 1), wb0_reg (in, ADDR_W), wb0_data (in, DATA_W) and wb0_ready (out, 1): the ALU writeback requester.
REQ-008 The block SHALL have ports wb1_valid (in, 1), wb1_reg (in, ADDR_W), wb1_data (in, DATA_W) and wb1_ready (out, 1): the load/multi-cycle writeback requester.
REQ-009 The block SHALL have ports chk_reg1 and chk_reg2, inputs, ADDR_W each: source registers queried by decode.
REQ-010 The block SHALL have ports chk_busy1 and chk_busy2, outputs, 1 bit each: the queried register has a pending write.
REQ-011 The block SHALL have port EnableWrite, output, 1 bit: write strobe to the register file.
REQ-012 The block SHALL have port write_reg, output, ADDR_W: the register file write index.
REQ-013 The block SHALL have port write_data, output, DATA_W: the register file write data.
REQ-014 The block SHALL have port busy_map, output, 32 bits: the scoreboard; bit n set means register n has a pending write.

Function
REQ-015 A handshake SHALL occur on requester k in any cycle where wbk_valid and wbk_ready are both 1; at most one handshake SHALL occur per cycle.
REQ-016 wbk_ready SHALL be combinational: 1 when wbk_valid=1 and requester k wins arbitration this cycle, else 0.
REQ-017 If only one requester is valid, it SHALL win.
REQ-018 If both requesters are valid, the requester not recorded in the last_grant register SHALL win.
REQ-019 last_grant SHALL update to the winner on every handshake and hold otherwise.
REQ-020 On a handshake, write_reg and write_data SHALL register the winner's reg/data, and EnableWrite SHALL be 1 for exactly the following cycle (latency 1).
REQ-021 On a cycle with no handshake, EnableWrite SHALL be 0 in the next cycle, and write_reg/write_data SHALL hold their values.
REQ-022 A handshake with reg=0 SHALL complete normally, but EnableWrite SHALL remain 0 for it.
REQ-023 rsv_valid=1 with rsv_reg!=0 SHALL set busy_map[rsv_reg] at the clock edge; a reservation of register 0 SHALL be ignored.
REQ-024 A handshake SHALL clear busy_map[winner reg] at the same edge that loads the output registers.
REQ-025 If a reservation and a handshake clear target the same register in the same cycle, the set SHALL win (the bit ends at 1).
REQ-026 A handshake to a register whose busy bit is 0 SHALL still be written and SHALL leave the bit at 0.
REQ-027 chk_busyN SHALL be combinational and equal busy_map[chk_regN]; it SHALL be 0 when chk_regN=0.
REQ-028 A requester holding valid while losing SHALL keep its reg/data stable, and it SHALL win on the next cycle whenever the other requester won the current one (no starvation beyond 1 cycle).

Reset
REQ-029 While rst_n=0, the block SHALL immediately, without waiting for a clock edge, force EnableWrite=0, write_reg=0, write_data=0, busy_map=0 and last_grant=wb1 (so wb0 wins the first contention).
REQ-030 While rst_n=0, wb0_ready and wb1_ready SHALL be 0.
REQ-031 A reset asserted mid-operation SHALL discard any registered write, with no EnableWrite pulse after release, and SHALL clear all reservations.

Verification
REQ-032 Bench: wb0 only, reg=7, data=0xDEADBEEF -> same cycle wb0_ready=1; next cycle EnableWrite=1, write_reg=7, write_data=0xDEADBEEF; the cycle after that, EnableWrite=0.
REQ-033 Bench: both valid for 4 cycles after reset (regs 3/4) -> grants wb0, wb1, wb0, wb1; EnableWrite held at 1 with write_reg 3, 4, 3, 4.
REQ-034 Bench: rsv reg 9, then chk_reg1=9 -> chk_busy1=1; wb1 handshake to reg 9 -> busy_map[9]=0 on the next cycle, chk_busy1=0.
REQ-035 Bench: same-cycle rsv_reg=5 and handshake to reg 5 with bit 5 already set -> busy_map[5] stays 1 and EnableWrite pulses for reg 5.
REQ-036 Bench: handshake to reg 0, and rsv_reg=0 -> wb ready=1, EnableWrite stays 0, busy_map stays 0.
REQ-037 Bench: rst_n dropped in the cycle after a handshake -> EnableWrite=0 and busy_map=0 asynchronously, with no write pulse after release.
